// File: rtl/l1_ctrl_pkg.sv
// rtl/l1_ctrl_pkg.sv - shared constants and read-FSM encoding for the L1 buffer sequencer
package l1_ctrl_pkg;

    localparam int ADDRWIDTH = 7;
    localparam int OVFWIDTH  = 8;
    localparam int DEPTH     = 1 << ADDRWIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRELOAD = 2'd1,
        LOAD    = 2'd2,
        BUSY    = 2'd3
    } rd_state_e;

endpackage

// File: rtl/l1_buffer_sequencer_if.sv
// rtl/l1_buffer_sequencer_if.sv - L1 accept/readout handshake and pixel fan-out bundle
interface l1_buffer_sequencer_if #(
    parameter int ADDRWIDTH = 7,
    parameter int OVFWIDTH  = 8
);
    logic                 L1A;
    logic                 evtReq;
    logic                 evtDone;
    logic                 wren;
    logic [ADDRWIDTH-1:0] wrAddr;
    logic [ADDRWIDTH-1:0] rdAddr;
    logic                 preLoad;
    logic                 load;
    logic                 evtGnt;
    logic                 full;
    logic                 empty;
    logic [ADDRWIDTH:0]   occupancy;
    logic                 overflow;
    logic [OVFWIDTH-1:0]  dropCount;

    modport master (
        output L1A, evtReq, evtDone,
        input  wren, wrAddr, rdAddr, preLoad, load, evtGnt,
        input  full, empty, occupancy, overflow, dropCount
    );

    modport slave (
        input  L1A, evtReq, evtDone,
        output wren, wrAddr, rdAddr, preLoad, load, evtGnt,
        output full, empty, occupancy, overflow, dropCount
    );
endinterface

// File: rtl/l1_occupancy_counter.sv
// rtl/l1_occupancy_counter.sv - up/down event counter with registered full/empty flags
module l1_occupancy_counter #(
    parameter int ADDRWIDTH = 7
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [ADDRWIDTH:0]   occupancy_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [ADDRWIDTH:0] OCC_ONE = {{ADDRWIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRWIDTH:0] DEPTH_C = {1'b1, {ADDRWIDTH{1'b0}}};

    logic [ADDRWIDTH:0] occ_q, occ_d;
    logic               full_q, empty_q;

    always_comb begin
        occ_d = occ_q;
        if (inc_i && !dec_i) begin
            occ_d = occ_q + OCC_ONE;
        end else if (dec_i && !inc_i) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    // Flags decode the next count so they line up with the registered count.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            full_q  <= (occ_d == DEPTH_C);
            empty_q <= (occ_d == '0);
        end
    end

    assign occupancy_o = occ_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;

endmodule

// File: rtl/l1_buffer_sequencer.sv
// rtl/l1_buffer_sequencer.sv - L1 write pointer pipeline, preLoad/load/release read FSM, drop tracking
import l1_ctrl_pkg::*;

module l1_buffer_sequencer #(
    parameter int ADDRWIDTH = l1_ctrl_pkg::ADDRWIDTH,
    parameter int OVFWIDTH  = l1_ctrl_pkg::OVFWIDTH
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    l1_buffer_sequencer_if.slave    bus
);

    localparam logic [ADDRWIDTH-1:0] ADDR_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};
    localparam logic [OVFWIDTH-1:0]  DROP_ONE = {{(OVFWIDTH-1){1'b0}}, 1'b1};

    rd_state_e            state_q, state_d;
    logic [ADDRWIDTH-1:0] wr_ptr_q, wr_pipe_q, wr_addr_q, rd_ptr_q;
    logic                 wren_q, preload_q, preload_d, load_q, load_d;
    logic                 overflow_q;
    logic [OVFWIDTH-1:0]  drop_cnt_q;
    logic [ADDRWIDTH:0]   occupancy;
    logic                 full, empty;
    logic                 accept, drop, release_evt;

    assign accept      = bus.L1A && !full;
    assign drop        = bus.L1A && full;
    assign release_evt = (state_q == BUSY) && bus.evtDone;

    // wrAddr trails wren by one cycle so pixels see the address after the enable.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wren_q    <= 1'b0;
            wr_ptr_q  <= '0;
            wr_pipe_q <= '0;
            wr_addr_q <= '0;
        end else begin
            wren_q <= accept;
            if (accept) begin
                wr_pipe_q <= wr_ptr_q;
                wr_ptr_q  <= wr_ptr_q + ADDR_ONE;
            end
            if (wren_q) begin
                wr_addr_q <= wr_pipe_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (!(&drop_cnt_q)) begin
                drop_cnt_q <= drop_cnt_q + DROP_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rd_ptr_q <= '0;
        end else if (release_evt) begin
            rd_ptr_q <= rd_ptr_q + ADDR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            preload_q <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            preload_q <= preload_d;
            load_q    <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.evtReq && !empty) state_d = PRELOAD;
            PRELOAD: state_d = LOAD;
            LOAD:    state_d = BUSY;
            BUSY:    if (bus.evtDone) state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they register alongside it.
    always_comb begin
        preload_d = (state_d == PRELOAD);
        load_d    = (state_d == LOAD);
    end

    l1_occupancy_counter #(
        .ADDRWIDTH (ADDRWIDTH)
    ) u_occ (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .inc_i       (accept),
        .dec_i       (release_evt),
        .occupancy_o (occupancy),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign bus.wren      = wren_q;
    assign bus.wrAddr    = wr_addr_q;
    assign bus.rdAddr    = rd_ptr_q;
    assign bus.preLoad   = preload_q;
    assign bus.load      = load_q;
    assign bus.evtGnt    = load_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.occupancy = occupancy;
    assign bus.overflow  = overflow_q;
    assign bus.dropCount = drop_cnt_q;

endmodule

// File: tb/tb_l1_buffer_sequencer.sv
// tb/tb_l1_buffer_sequencer.sv - directed self-checking bench for l1_buffer_sequencer
module tb_l1_buffer_sequencer;

    localparam int AW = 7;
    localparam int OW = 8;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk_i = ~clk_i;

    l1_buffer_sequencer_if #(.ADDRWIDTH(AW), .OVFWIDTH(OW)) bus ();

    l1_buffer_sequencer #(.ADDRWIDTH(AW), .OVFWIDTH(OW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_wren"},      32'(bus.wren),      0);
        check_val({tag, "_wrAddr"},    32'(bus.wrAddr),    0);
        check_val({tag, "_rdAddr"},    32'(bus.rdAddr),    0);
        check_val({tag, "_preLoad"},   32'(bus.preLoad),   0);
        check_val({tag, "_load"},      32'(bus.load),      0);
        check_val({tag, "_evtGnt"},    32'(bus.evtGnt),    0);
        check_val({tag, "_full"},      32'(bus.full),      0);
        check_val({tag, "_empty"},     32'(bus.empty),     1);
        check_val({tag, "_occupancy"}, 32'(bus.occupancy), 0);
        check_val({tag, "_overflow"},  32'(bus.overflow),  0);
        check_val({tag, "_dropCount"}, 32'(bus.dropCount), 0);
    endtask

    task automatic do_reset();
        reset_i     = 1'b0;
        bus.L1A     = 1'b0;
        bus.evtReq  = 1'b0;
        bus.evtDone = 1'b0;
        step();
        step();
        reset_i = 1'b1;
    endtask

    // Full readout of one event: PRELOAD, LOAD, BUSY (+busy_wait), then evtDone.
    task automatic read_event(input logic [31:0] exp_addr, input int busy_wait, input logic l1a_at_done);
        bus.evtReq = 1'b1;
        step();
        check_val("rd_preLoad", 32'(bus.preLoad), 1);
        check_val("rd_preLoad_noload", 32'(bus.load), 0);
        check_val("rd_addr_preload", 32'(bus.rdAddr), exp_addr);
        step();
        bus.evtReq = 1'b0;
        check_val("rd_load", 32'(bus.load), 1);
        check_val("rd_evtGnt", 32'(bus.evtGnt), 1);
        check_val("rd_load_nopreload", 32'(bus.preLoad), 0);
        step();
        check_val("rd_busy_load", 32'(bus.load), 0);
        check_val("rd_addr_busy", 32'(bus.rdAddr), exp_addr);
        repeat (busy_wait) step();
        bus.evtDone = 1'b1;
        bus.L1A     = l1a_at_done;
        step();
        bus.evtDone = 1'b0;
        bus.L1A     = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] mw;
        logic [AW-1:0] exp_q[$];

        do_reset();
        check_reset_state("reset");

        // 1: single L1A
        repeat (3) step();
        bus.L1A = 1'b1;
        step();
        bus.L1A = 1'b0;
        check_val("t1_wren", 32'(bus.wren), 1);
        check_val("t1_occ", 32'(bus.occupancy), 1);
        check_val("t1_empty", 32'(bus.empty), 0);
        step();
        check_val("t1_wren_off", 32'(bus.wren), 0);
        check_val("t1_wrAddr", 32'(bus.wrAddr), 0);

        // 2: three back-to-back L1As
        do_reset();
        bus.L1A = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t2_wren", 32'(bus.wren), 1);
            if (i > 0) check_val("t2_wrAddr", 32'(bus.wrAddr), 32'(i - 1));
        end
        bus.L1A = 1'b0;
        step();
        check_val("t2_wren_off", 32'(bus.wren), 0);
        check_val("t2_wrAddr_last", 32'(bus.wrAddr), 2);
        check_val("t2_occ", 32'(bus.occupancy), 3);
        step();
        check_val("t2_wrAddr_hold", 32'(bus.wrAddr), 2);

        // 3: readout with occupancy 2
        do_reset();
        bus.L1A = 1'b1;
        step();
        step();
        bus.L1A = 1'b0;
        step();
        step();
        check_val("t3_occ_before", 32'(bus.occupancy), 2);
        read_event(0, 8, 1'b0);
        check_val("t3_rdAddr", 32'(bus.rdAddr), 1);
        check_val("t3_occ", 32'(bus.occupancy), 1);
        check_val("t3_idle_preLoad", 32'(bus.preLoad), 0);

        // 4: fill, drop, release, refill
        do_reset();
        bus.L1A = 1'b1;
        for (int i = 0; i < 128; i++) begin
            step();
            check_val("t4_fill_wren", 32'(bus.wren), 1);
        end
        check_val("t4_full", 32'(bus.full), 1);
        check_val("t4_occ_full", 32'(bus.occupancy), 128);
        step();
        check_val("t4_drop1_wren", 32'(bus.wren), 0);
        step();
        check_val("t4_drop2_wren", 32'(bus.wren), 0);
        bus.L1A = 1'b0;
        check_val("t4_dropCount", 32'(bus.dropCount), 2);
        check_val("t4_overflow", 32'(bus.overflow), 1);
        check_val("t4_occ_after_drop", 32'(bus.occupancy), 128);
        check_val("t4_wrAddr_last", 32'(bus.wrAddr), 127);
        read_event(0, 0, 1'b1);
        check_val("t4_rel_l1a_wren", 32'(bus.wren), 0);
        check_val("t4_rel_l1a_drop", 32'(bus.dropCount), 3);
        check_val("t4_rel_full", 32'(bus.full), 0);
        check_val("t4_rel_occ", 32'(bus.occupancy), 127);
        bus.L1A = 1'b1;
        step();
        bus.L1A = 1'b0;
        check_val("t4_refill_wren", 32'(bus.wren), 1);
        check_val("t4_refill_full", 32'(bus.full), 1);
        step();
        check_val("t4_refill_wrAddr", 32'(bus.wrAddr), 0);
        check_val("t4_overflow_sticky", 32'(bus.overflow), 1);

        // 5: wrap with 200 accept/release pairs
        do_reset();
        mw = '0;
        for (int i = 0; i < 200; i++) begin
            bus.L1A = 1'b1;
            step();
            bus.L1A = 1'b0;
            check_val("t5_wren", 32'(bus.wren), 1);
            step();
            check_val("t5_wrAddr", 32'(bus.wrAddr), 32'(mw));
            exp_q.push_back(mw);
            mw = mw + 7'd1;
            read_event(32'(exp_q.pop_front()), 0, 1'b0);
        end
        check_val("t5_empty", 32'(bus.empty), 1);
        check_val("t5_occ", 32'(bus.occupancy), 0);
        check_val("t5_rdAddr", 32'(bus.rdAddr), 72);

        // 6: simultaneous accept/release, then reset during BUSY
        do_reset();
        bus.L1A = 1'b1;
        repeat (5) step();
        bus.L1A = 1'b0;
        step();
        check_val("t6_occ5", 32'(bus.occupancy), 5);
        read_event(0, 1, 1'b1);
        check_val("t6_same_occ", 32'(bus.occupancy), 5);
        check_val("t6_same_wren", 32'(bus.wren), 1);
        bus.evtReq = 1'b1;
        step();
        step();
        bus.evtReq = 1'b0;
        step();
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        check_reset_state("t6_rst");
        bus.evtDone = 1'b1;
        step();
        bus.evtDone = 1'b0;
        check_val("t6_late_done_occ", 32'(bus.occupancy), 0);
        check_val("t6_late_done_rdAddr", 32'(bus.rdAddr), 0);
        check_val("t6_late_done_empty", 32'(bus.empty), 1);
        bus.evtReq = 1'b1;
        step();
        step();
        check_val("t6_req_empty_preLoad", 32'(bus.preLoad), 0);
        check_val("t6_req_empty_load", 32'(bus.load), 0);
        bus.evtReq = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
